// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - idx_w(sets) - off_w(line_w);
  endfunction

  // Pointer width that stays at least one bit for a direct-mapped build
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU bookkeeping: per-set age permutation, victim choice and touch update.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter  int SETS  = 32,
  parameter  int WAYS  = 2,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = ptr_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [WAYS-1:0]  valid,
  output logic [WAY_W-1:0] victim,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [WAY_W-1:0] touch_way
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic             found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age_q[touch_idx][w] <= '0;
        else if (age_q[touch_idx][w] < age_q[touch_idx][touch_way])
          age_q[touch_idx][w] <= age_q[touch_idx][w] + WAY_W'(1);
      end
    end
  end

  // Fill empty ways first (lowest index), otherwise evict the oldest way
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[idx][w] == WAY_W'(WAYS - 1))
          victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with true-LRU
// replacement and saturating hit/miss counters.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WAY_W  = ptr_w(WAYS);
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int BYTE_W = OFF_W - WSEL_W;

  state_t                   state_q, state_d;
  logic                     req, hit, idle_hit, retry_q, refill_done, wr_hit, touch;
  logic [IDX_W-1:0]         req_idx, miss_idx, rd_idx, touch_idx;
  logic [TAG_W-1:0]         req_tag, miss_tag;
  logic [WAY_W-1:0]         hit_way, vic_way_q, lru_victim, touch_way;
  logic [WSEL_W-1:0]        word_sel;
  logic [WAYS-1:0]          rd_valid, rd_dirty, way_hit;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][LINE_W-1:0] rd_line;
  logic [LINE_W-1:0]        hit_line;
  logic                     unused_byte_bits;

  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
  assign word_sel         = p1_addr_i[BYTE_W +: WSEL_W];
  assign unused_byte_bits = ^p1_addr_i[BYTE_W-1:0];

  // Outside IDLE the arrays are read at the latched miss index (victim line/tag)
  assign rd_idx      = (state_q == IDLE) ? req_idx : miss_idx;
  assign hit         = |way_hit;
  assign idle_hit    = (state_q == IDLE) && hit;
  assign refill_done = (state_q == REFILL) && mem_ack_i;
  assign wr_hit      = idle_hit && p1_MemWrite_i;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];
    logic [SETS-1:0]   valid_q, dirty_q;
    logic              fill, wr;

    assign fill = refill_done && (vic_way_q == WAY_W'(w));
    assign wr   = wr_hit && way_hit[w];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= '0;
        dirty_q <= '0;
      end else if (fill) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end else if (wr) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (fill) begin
        tag_q[miss_idx]  <= miss_tag;
        data_q[miss_idx] <= mem_data_i;
      end else if (wr) begin
        data_q[req_idx][int'(word_sel)*WORD_W +: WORD_W] <= p1_data_i;
      end
    end

    assign rd_valid[w] = valid_q[rd_idx];
    assign rd_dirty[w] = dirty_q[rd_idx];
    assign rd_tag[w]   = tag_q[rd_idx];
    assign rd_line[w]  = data_q[rd_idx];
    assign way_hit[w]  = valid_q[rd_idx] && (tag_q[rd_idx] == req_tag);
  end

  always_comb begin
    hit_line = '0;
    hit_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_line = rd_line[w];
        hit_way  = WAY_W'(w);
      end
    end
  end

  assign p1_data_o  = idle_hit ? hit_line[int'(word_sel)*WORD_W +: WORD_W] : '0;
  assign p1_stall_o = req && !idle_hit;

  // Installed line becomes MRU at fill time so a dropped request still ages correctly
  assign touch     = (idle_hit && req) || refill_done;
  assign touch_idx = refill_done ? miss_idx : req_idx;
  assign touch_way = refill_done ? vic_way_q : hit_way;

  dcache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (clk_i),
    .rst       (rst_i),
    .idx       (rd_idx),
    .valid     (rd_valid),
    .victim    (lru_victim),
    .touch     (touch),
    .touch_idx (touch_idx),
    .touch_way (touch_way)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      vic_way_q  <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      retry_q    <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= refill_done;
      if ((state_q == IDLE) && req && !hit) begin
        vic_way_q <= lru_victim;
        miss_idx  <= req_idx;
        miss_tag  <= req_tag;
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
      // The retry after a fill is the same access that already counted as a miss
      if (idle_hit && req && !retry_q && (hit_cnt_o != '1))
        hit_cnt_o <= hit_cnt_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {miss_tag, miss_idx, {OFF_W{1'b0}}};
    mem_data_o   = rd_line[vic_way_q];
    case (state_q)
      IDLE: begin
        if (req && !hit)
          state_d = (rd_valid[lru_victim] && rd_dirty[lru_victim]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag[vic_way_q], miss_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: default 2-way build plus 1-way and 4-way builds
// sharing one line-memory model that acks 3 cycles after enable.
module tb_dcache_assoc;

  localparam int ACK_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  p1_addr = '0, p1_wdata = '0;
  logic         p1_rd = 1'b0, p1_wr = 1'b0;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;
  int           sel = 0;

  logic [31:0]  d_rdata [3];
  logic         d_stall [3];
  logic [255:0] d_mdata [3];
  logic [31:0]  d_maddr [3];
  logic         d_men   [3];
  logic         d_mwr   [3];
  logic [31:0]  d_hit   [3];
  logic [31:0]  d_miss  [3];

  dcache_assoc #(.WAYS(2)) dut (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd && sel == 0), .p1_MemWrite_i(p1_wr && sel == 0),
    .p1_data_o(d_rdata[0]), .p1_stall_o(d_stall[0]),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack && sel == 0),
    .mem_data_o(d_mdata[0]), .mem_addr_o(d_maddr[0]), .mem_enable_o(d_men[0]),
    .mem_write_o(d_mwr[0]), .hit_cnt_o(d_hit[0]), .miss_cnt_o(d_miss[0]));

  dcache_assoc #(.WAYS(1)) dut_w1 (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd && sel == 1), .p1_MemWrite_i(p1_wr && sel == 1),
    .p1_data_o(d_rdata[1]), .p1_stall_o(d_stall[1]),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack && sel == 1),
    .mem_data_o(d_mdata[1]), .mem_addr_o(d_maddr[1]), .mem_enable_o(d_men[1]),
    .mem_write_o(d_mwr[1]), .hit_cnt_o(d_hit[1]), .miss_cnt_o(d_miss[1]));

  dcache_assoc #(.WAYS(4)) dut_w4 (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd && sel == 2), .p1_MemWrite_i(p1_wr && sel == 2),
    .p1_data_o(d_rdata[2]), .p1_stall_o(d_stall[2]),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack && sel == 2),
    .mem_data_o(d_mdata[2]), .mem_addr_o(d_maddr[2]), .mem_enable_o(d_men[2]),
    .mem_write_o(d_mwr[2]), .hit_cnt_o(d_hit[2]), .miss_cnt_o(d_miss[2]));

  logic [31:0]  rdata, maddr, hitc, missc;
  logic [255:0] mdata;
  logic         stall, men, mwr;
  assign rdata = d_rdata[sel];
  assign stall = d_stall[sel];
  assign mdata = d_mdata[sel];
  assign maddr = d_maddr[sel];
  assign men   = d_men[sel];
  assign mwr   = d_mwr[sel];
  assign hitc  = d_hit[sel];
  assign missc = d_miss[sel];

  logic [255:0] mem_model [logic [31:0]];

  int          n_checks = 0, n_fail = 0;
  int          stall_g, wb_count, rf_count;
  logic [31:0] rdata_g, last_wb_addr, last_wb_word0, last_rf_addr;
  logic        en_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Word k of an untouched line at address a reads back as a + 4k
  function automatic logic [255:0] dflt_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a + 32'(k * 4);
    return l;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; runs one CPU access to completion while serving memory
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int en_cnt = 0;
    bit done = 1'b0;
    p1_addr = addr; p1_wdata = wdata; p1_wr = wr; p1_rd = !wr;
    stall_g = 0; en_seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (men) en_seen = 1'b1;
      if (!stall) begin
        rdata_g = rdata;
        done = 1'b1;
      end else begin
        stall_g++;
        if (men) begin
          en_cnt++;
          if (en_cnt == 1) begin
            if (mwr) begin
              wb_count++; last_wb_addr = maddr; last_wb_word0 = mdata[31:0];
            end else begin
              rf_count++; last_rf_addr = maddr;
            end
          end
          if (en_cnt == ACK_LAT + 1) begin
            mem_ack = 1'b1;
            en_cnt = 0;
            if (mwr) mem_model[maddr] = mdata;
            else mem_rdata = mem_model.exists(maddr) ? mem_model[maddr] : dflt_line(maddr);
          end
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    check("access_done", 32'(done), 32'd1);
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  logic [31:0] w1_addr  [4]  = '{32'h060, 32'h060, 32'h460, 32'h060};
  int          w1_stall [4]  = '{5, 0, 5, 5};
  logic [31:0] w4_addr  [10] = '{32'h060, 32'h460, 32'h860, 32'hC60, 32'h060,
                                 32'h1060, 32'h060, 32'h860, 32'hC60, 32'h460};
  int          w4_stall [10] = '{5, 5, 5, 5, 0, 5, 0, 0, 0, 5};

  initial begin
    logic [255:0] pre;
    int wb_before;
    wb_count = 0; rf_count = 0;
    pre = dflt_line(32'h40);
    pre[63:32] = 32'hDEADBEEF;
    mem_model[32'h40] = pre;

    // Reset state
    @(negedge clk);
    p1_rd = 1'b1; p1_addr = 32'h44;
    #1;
    check("rst_stall_eq_req", 32'(stall), 32'd1);
    check("rst_mem_enable", 32'(men), 32'd0);
    check("rst_mem_write", 32'(mwr), 32'd0);
    check("rst_hit_cnt", hitc, 32'd0);
    check("rst_miss_cnt", missc, 32'd0);
    p1_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Cold read
    access(1'b0, 32'h44, 32'h0);
    check("cold_refill_addr", last_rf_addr, 32'h40);
    check("cold_no_writeback", 32'(wb_count), 32'd0);
    check("cold_rdata", rdata_g, 32'hDEADBEEF);
    check("cold_stall_cycles", 32'(stall_g), 32'd5);
    check("cold_miss_cnt", missc, 32'd1);
    check("cold_hit_cnt", hitc, 32'd0);

    // Two-way residency
    do_reset();
    access(1'b0, 32'h000, 32'h0);
    check("res_a_stall", 32'(stall_g), 32'd5);
    access(1'b0, 32'h400, 32'h0);
    check("res_b_rdata", rdata_g, 32'h400);
    access(1'b0, 32'h000, 32'h0);
    check("res_reread_stall", 32'(stall_g), 32'd0);
    check("res_reread_no_mem", 32'(en_seen), 32'd0);
    check("res_hit_cnt", hitc, 32'd1);
    check("res_miss_cnt", missc, 32'd2);

    // LRU eviction of 0x400
    wb_count = 0;
    access(1'b0, 32'h800, 32'h0);
    check("lru_evict_stall", 32'(stall_g), 32'd5);
    check("lru_evict_no_wb", 32'(wb_count), 32'd0);
    check("lru_evict_rdata", rdata_g, 32'h800);
    access(1'b0, 32'h000, 32'h0);
    check("lru_keep_mru_stall", 32'(stall_g), 32'd0);
    check("lru_keep_mru_no_mem", 32'(en_seen), 32'd0);

    // Dirty writeback
    access(1'b1, 32'h000, 32'h12345678);
    check("wr_hit_stall", 32'(stall_g), 32'd0);
    access(1'b0, 32'h400, 32'h0);
    check("touch_400_stall", 32'(stall_g), 32'd5);
    check("touch_400_no_wb", 32'(wb_count), 32'd0);
    access(1'b0, 32'h800, 32'h0);
    check("dirty_wb_count", 32'(wb_count), 32'd1);
    check("dirty_wb_addr", last_wb_addr, 32'h000);
    check("dirty_wb_word0", last_wb_word0, 32'h12345678);
    check("dirty_refill_addr", last_rf_addr, 32'h800);
    check("dirty_stall_cycles", 32'(stall_g), 32'd9);
    check("dirty_rdata", rdata_g, 32'h800);
    access(1'b0, 32'h000, 32'h0);
    check("wb_data_readback", rdata_g, 32'h12345678);
    check("wb_readback_stall", 32'(stall_g), 32'd5);

    // Write miss allocates, then reads back
    access(1'b1, 32'h0C4, 32'hA5A55A5A);
    check("wmiss_stall", 32'(stall_g), 32'd5);
    access(1'b0, 32'h0C4, 32'h0);
    check("wmiss_readback", rdata_g, 32'hA5A55A5A);
    check("wmiss_readback_stall", 32'(stall_g), 32'd0);
    access(1'b0, 32'h0C0, 32'h0);
    check("wmiss_neighbour_word", rdata_g, 32'h0C0);
    check("acc_hit_cnt", hitc, 32'd5);
    check("acc_miss_cnt", missc, 32'd7);

    // Reset mid-WRITEBACK
    access(1'b1, 32'h000, 32'hCAFEF00D);
    access(1'b0, 32'h400, 32'h0);
    check("pre_abort_stall", 32'(stall_g), 32'd5);
    p1_addr = 32'h800; p1_rd = 1'b1;
    #1;
    check("abort_detect_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("abort_wb_enable", 32'(men), 32'd1);
    check("abort_wb_write", 32'(mwr), 32'd1);
    check("abort_wb_addr", maddr, 32'h000);
    rst = 1'b1;
    #1;
    check("abort_enable_drop", 32'(men), 32'd0);
    check("abort_hit_cnt", hitc, 32'd0);
    check("abort_miss_cnt", missc, 32'd0);
    check("abort_stall_eq_req", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b0; p1_rd = 1'b0;
    wb_before = wb_count;
    access(1'b0, 32'h000, 32'h0);
    check("post_abort_miss_stall", 32'(stall_g), 32'd5);
    check("post_abort_dirty_lost", rdata_g, 32'h12345678);
    check("post_abort_no_wb", 32'(wb_count - wb_before), 32'd0);

    // Ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = '1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("idle_ack_enable", 32'(men), 32'd0);
    @(negedge clk);
    access(1'b0, 32'h000, 32'h0);
    check("idle_ack_hit_stall", 32'(stall_g), 32'd0);
    check("idle_ack_rdata", rdata_g, 32'h12345678);
    check("idle_ack_hit_cnt", hitc, 32'd1);
    check("idle_ack_miss_cnt", missc, 32'd1);

    // Direct-mapped build: conflicts in set 3
    sel = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(1'b0, w1_addr[i], 32'h0);
      check($sformatf("w1_stall_%0d", i), 32'(stall_g), 32'(w1_stall[i]));
      check($sformatf("w1_rdata_%0d", i), rdata_g, w1_addr[i]);
    end
    check("w1_hit_cnt", hitc, 32'd1);
    check("w1_miss_cnt", missc, 32'd3);

    // Four-way build: five tags in set 3, LRU victim each time
    sel = 2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      access(1'b0, w4_addr[i], 32'h0);
      check($sformatf("w4_stall_%0d", i), 32'(stall_g), 32'(w4_stall[i]));
      check($sformatf("w4_rdata_%0d", i), rdata_g, w4_addr[i]);
    end
    check("w4_hit_cnt", hitc, 32'd4);
    check("w4_miss_cnt", missc, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
